// File: rtl/lfsr_descrambler.sv
// Receive-side 301-bit Galois LFSR descrambler with IDLE/RUN control and valid/ready on both sides.
// Define LFSR_DESCRAMBLER_SYNC_CHECK_EN to add the first-word SYNC_WORD check and the sync_err port.
module lfsr_descrambler #(
   parameter int POLY_WIDTH   = 301,
   parameter int NUM_OF_STEPS = 15
`ifdef LFSR_DESCRAMBLER_SYNC_CHECK_EN
   ,
   parameter logic [NUM_OF_STEPS-1:0] SYNC_WORD = 15'h4A53
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    write,
   input  logic [11:0]             addr,
   input  logic [31:0]             lfsrdin,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_OF_STEPS-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NUM_OF_STEPS-1:0] out_data,
   output logic                    busy,
   output logic                    seed_err,
   output logic [31:0]             word_cnt
`ifdef LFSR_DESCRAMBLER_SYNC_CHECK_EN
   ,
   output logic                    sync_err
`endif
);

   localparam logic [11:0] SEED_BASE = 12'h071;
   localparam logic [11:0] SEED_TOP  = 12'h07A;
   localparam logic [11:0] CTRL_ADDR = 12'h07B;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                  state;
   logic [POLY_WIDTH-1:0]   lfsr;
   logic [POLY_WIDTH-1:0]   lfsr_next;
   logic [POLY_WIDTH-1:0]   walk;
   logic [NUM_OF_STEPS-1:0] ks;
   logic [NUM_OF_STEPS-1:0] plain;
   logic                    ctrl_wr;
   logic                    start_req;
   logic                    abort_req;
   logic                    start_ok;
   logic                    start_zero;
   logic                    seed_wr;
   logic                    accept;
`ifdef LFSR_DESCRAMBLER_SYNC_CHECK_EN
   logic                    first_beat;
`endif

   // Feedback is the bit shifted out of the top; it re-enters at bit 0 and is XORed in after taps 180/208/214.
   function automatic logic [POLY_WIDTH-1:0] lfsr_step(input logic [POLY_WIDTH-1:0] s);
      logic [POLY_WIDTH-1:0] n;
      logic                  fb;
      fb     = s[POLY_WIDTH-1];
      n      = {s[POLY_WIDTH-2:0], fb};
      n[181] = s[180] ^ fb;
      n[209] = s[208] ^ fb;
      n[215] = s[214] ^ fb;
      return n;
   endfunction

   always_comb begin
      walk = lfsr;
      ks   = '0;
      for (int k = 0; k < NUM_OF_STEPS; k++) begin
         ks[k] = walk[POLY_WIDTH-1];
         walk  = lfsr_step(walk);
      end
      lfsr_next = walk;
   end

   assign plain      = in_data ^ ks;
   assign ctrl_wr    = write && (addr == CTRL_ADDR);
   assign abort_req  = ctrl_wr && lfsrdin[1];
   assign start_req  = ctrl_wr && lfsrdin[0] && !lfsrdin[1];
   assign start_ok   = start_req && (state == IDLE) && (lfsr != '0);
   assign start_zero = start_req && (state == IDLE) && (lfsr == '0);
   assign seed_wr    = write && (state == IDLE);
   assign busy       = (state == RUN);
   assign in_ready   = (state == RUN) && (!out_valid || out_ready);
   // An ABORT in the same cycle drops the beat entirely, so it never reaches the LFSR or counter.
   assign accept     = in_valid && in_ready && !abort_req;

   always_ff @(posedge clk) begin
      if (!rst) begin
         lfsr       <= '0;
         state      <= IDLE;
         out_valid  <= 1'b0;
         out_data   <= '0;
         seed_err   <= 1'b0;
         word_cnt   <= '0;
`ifdef LFSR_DESCRAMBLER_SYNC_CHECK_EN
         first_beat <= 1'b0;
         sync_err   <= 1'b0;
`endif
      end else begin
         if (seed_wr) begin
            for (int k = 0; k < 9; k++) begin
               if (addr == SEED_BASE + 12'(k)) begin
                  lfsr[32*k +: 32] <= lfsrdin;
               end
            end
            if (addr == SEED_TOP) begin
               lfsr[POLY_WIDTH-1 -: 13] <= lfsrdin[12:0];
            end
         end

         if (accept) begin
            lfsr <= lfsr_next;
         end

         if (abort_req) begin
            out_valid <= 1'b0;
         end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= plain;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (start_ok) begin
            word_cnt <= '0;
         end else if (accept && (word_cnt != 32'hFFFF_FFFF)) begin
            word_cnt <= word_cnt + 32'd1;
         end

         if (abort_req) begin
            state <= IDLE;
         end else if (start_ok) begin
            state    <= RUN;
            seed_err <= 1'b0;
`ifdef LFSR_DESCRAMBLER_SYNC_CHECK_EN
            sync_err   <= 1'b0;
            first_beat <= 1'b1;
`endif
         end else if (start_zero) begin
            seed_err <= 1'b1;
`ifdef LFSR_DESCRAMBLER_SYNC_CHECK_EN
         end else if (accept && first_beat) begin
            first_beat <= 1'b0;
            if (plain != SYNC_WORD) begin
               state    <= IDLE;
               sync_err <= 1'b1;
            end
`endif
         end
      end
   end

endmodule
